if_stage: RTL and testbench

- Instruction fetch stage of the pipelined RV32I core.
- Owns the PC and runs a single-outstanding request/response handshake with instruction memory.
- Drives the IF/ID pipeline register outputs (instruction, pc, valid) consumed by the ID/EX register.
- Honours hazard-unit stall/flush and EX-stage branch/jump redirects; discards stale responses.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/if_id_reg.sv | 76 +++++++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the pipelined RV32I core.
//   XLEN               : architectural register / address width
//   NOP_INSTR_DEFAULT  : addi x0,x0,0, the canonical pipeline bubble
//   RESET_PC_DEFAULT   : PC loaded when the core leaves reset
//   fetch_state_e      : fetch-side request tracking states
//   word_align()       : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // ISSUE   : nothing outstanding, the next request goes out from pc
    // WAIT    : one request outstanding and its word is wanted
    // DISCARD : one request outstanding but its word is stale (redirected)
    // BUF     : a returned word is parked because IF/ID could not take it
    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        BUF     = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Priority, highest first:
//   flush or redirect -> bubble (valid=0, NOP, pc kept)
//   stall             -> hold everything
//   load              -> capture the delivered instruction
//   otherwise         -> bubble
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   flush_i           : hazard-unit flush
//   redirect_i        : EX-stage taken branch/jump
//   stall_i           : hazard-unit stall
//   load_i            : fetch is delivering an instruction this cycle
//   instr_i, pc_i     : delivered instruction and its address
//   instr_o, pc_o,
//   valid_o           : registered IF/ID contents
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    // Next-state selection. A bubble keeps the old pc so that the value on
    // if_id_pc only ever changes when a real instruction is loaded.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i || redirect_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_d = instr_i;
                pc_d    = pc_i;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // Register update with synchronous reset to an invalid NOP at pc 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage of the RV32I pipeline. Owns the PC, keeps at most
// one instruction-memory request outstanding, and feeds the IF/ID register.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   imem_req, imem_addr       : request strobe and word-aligned address
//   imem_rvalid, imem_rdata   : in-order response strobe and instruction word
//   redirect_valid/_pc        : taken branch/jump target from EX
//   stall, flush              : hazard-unit controls
//   if_id_instruction/_pc/_valid : registered IF/ID outputs
// ----------------------------------------------------------------------------
module if_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;

    logic        hold;
    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] redirect_target;
    logic [31:0] pc_next_seq;
    logic        req_raw;

    assign hold            = stall | flush;
    assign redirect_target = word_align(redirect_pc);
    assign pc_next_seq     = pc_q + 32'd4;

    // A word is handed to IF/ID either straight from memory (WAIT) or from
    // the parking buffer (BUF); any hold or redirect blocks the hand-off.
    assign deliver = (((state_q == WAIT) && imem_rvalid) || (state_q == BUF))
                     && !hold && !redirect_valid;
    assign deliver_word = (state_q == BUF) ? buf_q : imem_rdata;

    // Fetch control. pc_q always names the outstanding request or the next
    // one to issue, so a delivery both advances pc and issues at pc+4 in the
    // same cycle to sustain one instruction per cycle. imem_rvalid seen in
    // ISSUE or BUF is a protocol violation and is simply ignored.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        req_raw   = 1'b0;
        imem_addr = word_align(pc_q);
        unique case (state_q)
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else begin
                    req_raw = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        pc_d    = redirect_target;
                        state_d = ISSUE;
                    end else if (hold) begin
                        buf_d   = imem_rdata;
                        state_d = BUF;
                    end else begin
                        pc_d      = pc_next_seq;
                        req_raw   = 1'b1;
                        imem_addr = word_align(pc_next_seq);
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                // The last redirect before the stale word returns wins.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            BUF: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = ISSUE;
                end else if (!hold) begin
                    pc_d      = pc_next_seq;
                    req_raw   = 1'b1;
                    imem_addr = word_align(pc_next_seq);
                    state_d   = WAIT;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    // No request may leave the stage while reset is held.
    assign imem_req = req_raw & rst;

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .redirect_i (redirect_valid),
        .stall_i    (stall),
        .load_i     (deliver),
        .instr_i    (deliver_word),
        .pc_i       (pc_q),
        .instr_o    (if_id_instruction),
        .pc_o       (if_id_pc),
        .valid_o    (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A small instruction memory answers each
// request after a chosen latency with addr ^ 32'hA5A5_0000, and a
// transaction-level model (in-flight request flag, wanted flag, parked word)
// predicts the request stream and the IF/ID contents every cycle.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state.
    bit          mOut;
    bit          mWanted;
    bit          mHeld;
    logic [31:0] mHeldWord;
    logic [31:0] mPc;
    bit          mValid;
    logic [31:0] mInstr;
    logic [31:0] mIfPc;

    // Instruction memory: in-order pending responses.
    logic [31:0] memAddrQ[$];
    int          memDueQ[$];
    int          lastDue    = 0;
    int          memLatency = 1;
    bit          randLat    = 1'b0;
    int          strayCount = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall             (stall),
        .flush             (flush),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid)
    );

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic modelReset();
        mOut      = 1'b0;
        mWanted   = 1'b0;
        mHeld     = 1'b0;
        mHeldWord = 32'h0;
        mPc       = RST_PC;
        mValid    = 1'b0;
        mInstr    = NOP;
        mIfPc     = 32'h0;
    endtask

    // Drive one cycle of inputs just after the rising edge; the memory
    // answers whichever pending request is due this cycle.
    task automatic applyStimulus(input bit r, input bit s, input bit f,
                                 input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        cycle++;
        rst            = r;
        stall          = s;
        flush          = f;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (memDueQ.size() > 0 && memDueQ[0] == cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memAddrQ[0] ^ DATA_KEY;
            void'(memAddrQ.pop_front());
            void'(memDueQ.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    // On the falling edge: compare DUT against the model, then advance the
    // model and the memory by one cycle.
    task automatic checkOutput();
        bit          hold, wordArr, hasWord, deliver, expReq;
        logic [31:0] expAddr, word, tgt;
        int          lat, due;
        @(negedge clk);
        expReq  = 1'b0;
        expAddr = 32'h0;
        deliver = 1'b0;
        wordArr = 1'b0;
        word    = 32'h0;
        hold    = stall | flush;
        tgt     = redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            wordArr = imem_rvalid && mOut;
            if (imem_rvalid && !mOut) begin
                strayCount++;
                $display("[TB] protocol monitor: imem_rvalid with nothing outstanding at cycle %0d (must be ignored)", cycle);
            end
            hasWord = (wordArr && mWanted) || mHeld;
            word    = mHeld ? mHeldWord : imem_rdata;
            deliver = hasWord && !hold && !redirect_valid;
            if (!mOut && !mHeld) begin
                expReq  = !redirect_valid;
                expAddr = mPc;
            end else if (deliver) begin
                expReq  = 1'b1;
                expAddr = mPc + 32'd4;
            end
        end

        checkEq("if_id_valid", 32'(if_id_valid), 32'(mValid));
        checkEq("if_id_instruction", if_id_instruction, mInstr);
        checkEq("if_id_pc", if_id_pc, mIfPc);
        checkEq("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) begin
            checkEq("imem_addr", imem_addr, expAddr);
            lat = randLat ? int'($urandom_range(1, 3)) : memLatency;
            due = (cycle + lat > lastDue) ? cycle + lat : lastDue + 1;
            memAddrQ.push_back(expAddr);
            memDueQ.push_back(due);
            lastDue = due;
        end

        if (!rst) begin
            modelReset();
        end else begin
            if (flush || redirect_valid) begin
                mValid = 1'b0;
                mInstr = NOP;
            end else if (!stall) begin
                if (deliver) begin
                    mValid = 1'b1;
                    mInstr = word;
                    mIfPc  = mPc;
                end else begin
                    mValid = 1'b0;
                    mInstr = NOP;
                end
            end
            if (redirect_valid) begin
                mPc   = tgt;
                mHeld = 1'b0;
                if (mOut) begin
                    if (wordArr) mOut = 1'b0;
                    else         mWanted = 1'b0;
                end
            end else if (deliver) begin
                mPc     = mPc + 32'd4;
                mOut    = 1'b1;
                mWanted = 1'b1;
                mHeld   = 1'b0;
            end else if (wordArr) begin
                if (mWanted) begin
                    mHeld     = 1'b1;
                    mHeldWord = imem_rdata;
                end
                mOut = 1'b0;
            end else if (!mOut && !mHeld) begin
                mOut    = 1'b1;
                mWanted = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f,
                        input bit rd, input logic [31:0] rpc);
        applyStimulus(r, s, f, rd, rpc);
        checkOutput();
    endtask

    initial begin
        bit found;
        modelReset();

        // Reset, then a straight-line stream with latency-1 memory.
        $display("[TB] reset and sequential fetch");
        memLatency = 1;
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 32'h0);

        // Three-cycle stall while a response lands: word parked, then delivered.
        $display("[TB] stall with response in flight");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);

        // Redirect to 0x100 while the slow request to 0x10 is outstanding.
        $display("[TB] redirect over an outstanding request");
        memLatency = 3;
        step(1, 0, 0, 1, 32'h0000_0010);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, 0, 32'h0);
            if (mOut && mWanted && mPc == 32'h0000_0010) found = 1'b1;
        end
        checkEq("reach_req_0x10", 32'(found), 32'd1);
        step(1, 0, 0, 1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 32'h0);

        // Misaligned target and wrap-around at the top of the address space.
        $display("[TB] aligned redirect and pc wrap");
        memLatency = 1;
        step(1, 0, 0, 1, 32'h0000_0203);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 32'h0);

        // Stall and flush together on a delivery cycle.
        $display("[TB] stall plus flush");
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h0);

        // Reset mid-WAIT; the old response returns after release.
        $display("[TB] reset with a request outstanding");
        memLatency = 3;
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 32'h0);

        // Randomised hazards, redirects and memory latency.
        $display("[TB] random traffic");
        randLat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1,
                 ($urandom % 5) == 0,
                 ($urandom % 9) == 0,
                 ($urandom % 8) == 0,
                 $urandom);
        end

        $display("[TB] stray responses seen by protocol monitor: %0d", strayCount);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
